// File: rtl/swt16_loader_if.sv
// Byte-stream input and memory write/status bundle between the boot stream,
// the loader, and the swt16 core memories.
interface swt16_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16
);
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  out_ready;
    logic                  out_pmem_wr_en;
    logic                  out_dmem_wr_en;
    logic [ADDR_WIDTH-1:0] out_wr_addr;
    logic [WORD_WIDTH-1:0] out_wr_word;
    logic                  out_core_reset;
    logic                  out_done;
    logic                  out_error;
    logic [11:0]           out_words_loaded;

    modport slave (
        input  in_byte, in_valid,
        output out_ready, out_pmem_wr_en, out_dmem_wr_en, out_wr_addr, out_wr_word,
               out_core_reset, out_done, out_error, out_words_loaded
    );

    modport master (
        output in_byte, in_valid,
        input  out_ready, out_pmem_wr_en, out_dmem_wr_en, out_wr_addr, out_wr_word,
               out_core_reset, out_done, out_error, out_words_loaded
    );
endinterface

// File: rtl/swt16_loader.sv
// Boot loader: parses framed big-endian byte stream into PMEM/DMEM word writes,
// holds the swt16 core in reset until a GO frame, locks up on any frame error.
module swt16_loader #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          WORD_WIDTH     = 16,
    parameter int          ADDR_INCREMENT = 2,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic          clock,
    input  logic          reset,
    swt16_loader_if.slave bus
);
    localparam int ADDR_LIMIT = 2 ** ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_TARGET, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO,
        S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN, S_ERROR
    } state_t;

    state_t                state;
    logic                  target_dmem;
    logic [7:0]            addr_hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_hi_q;
    logic [15:0]           count_q;
    logic [7:0]            csum_q;
    logic [7:0]            data_hi_q;

    logic        accept;
    logic [15:0] addr16;
    logic [15:0] len16;
    logic [16:0] end17;
    logic        addr_bad;
    logic        len_bad;

    always_comb begin
        accept   = bus.in_valid & bus.out_ready;
        addr16   = {addr_hi_q, bus.in_byte};
        len16    = {len_hi_q, bus.in_byte};
        // 17-bit end address so a frame ending exactly at the top of memory is legal
        end17    = 17'(addr_q) + {len16, 1'b0};
        addr_bad = ({1'b0, addr16} >= 17'(ADDR_LIMIT)) || addr16[0];
        len_bad  = (len16 == 16'd0) || (end17 > 17'(ADDR_LIMIT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= S_IDLE;
            target_dmem          <= 1'b0;
            addr_hi_q            <= '0;
            addr_q               <= '0;
            len_hi_q             <= '0;
            count_q              <= '0;
            csum_q               <= '0;
            data_hi_q            <= '0;
            bus.out_ready        <= 1'b0;
            bus.out_pmem_wr_en   <= 1'b0;
            bus.out_dmem_wr_en   <= 1'b0;
            bus.out_wr_addr      <= '0;
            bus.out_wr_word      <= '0;
            bus.out_core_reset   <= 1'b1;
            bus.out_done         <= 1'b0;
            bus.out_error        <= 1'b0;
            bus.out_words_loaded <= '0;
        end else begin
            bus.out_pmem_wr_en <= 1'b0;
            bus.out_dmem_wr_en <= 1'b0;
            if (state != S_RUN && state != S_ERROR)
                bus.out_ready <= 1'b1;

            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_byte == SYNC_BYTE)
                            state <= S_TARGET;
                    end
                    S_TARGET: begin
                        if (bus.in_byte == 8'h00 || bus.in_byte == 8'h01) begin
                            target_dmem <= bus.in_byte[0];
                            state       <= S_ADDR_HI;
                        end else if (bus.in_byte == 8'hFF && !bus.out_error) begin
                            state              <= S_RUN;
                            bus.out_ready      <= 1'b0;
                            bus.out_core_reset <= 1'b0;
                            bus.out_done       <= 1'b1;
                        end else begin
                            state         <= S_ERROR;
                            bus.out_ready <= 1'b0;
                            bus.out_error <= 1'b1;
                        end
                    end
                    S_ADDR_HI: begin
                        addr_hi_q <= bus.in_byte;
                        state     <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr_q <= addr16[ADDR_WIDTH-1:0];
                        if (addr_bad) begin
                            state         <= S_ERROR;
                            bus.out_ready <= 1'b0;
                            bus.out_error <= 1'b1;
                        end else begin
                            state <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi_q <= bus.in_byte;
                        state    <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (len_bad) begin
                            state         <= S_ERROR;
                            bus.out_ready <= 1'b0;
                            bus.out_error <= 1'b1;
                        end else begin
                            count_q <= len16;
                            csum_q  <= '0;
                            state   <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        data_hi_q <= bus.in_byte;
                        csum_q    <= csum_q ^ bus.in_byte;
                        state     <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        bus.out_pmem_wr_en <= ~target_dmem;
                        bus.out_dmem_wr_en <= target_dmem;
                        bus.out_wr_addr    <= addr_q;
                        bus.out_wr_word    <= WORD_WIDTH'({data_hi_q, bus.in_byte});
                        if (bus.out_words_loaded != 12'hFFF)
                            bus.out_words_loaded <= bus.out_words_loaded + 12'd1;
                        addr_q  <= addr_q + ADDR_WIDTH'(ADDR_INCREMENT);
                        csum_q  <= csum_q ^ bus.in_byte;
                        count_q <= count_q - 16'd1;
                        state   <= (count_q == 16'd1) ? S_CSUM : S_DATA_HI;
                    end
                    S_CSUM: begin
                        if (bus.in_byte == csum_q) begin
                            state <= S_IDLE;
                        end else begin
                            state         <= S_ERROR;
                            bus.out_ready <= 1'b0;
                            bus.out_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_swt16_loader.sv
// Randomized + directed scoreboard bench for swt16_loader using a frame-level
// reference model that predicts writes, accepted byte counts and final status.
module tb_swt16_loader;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    swt16_loader_if #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) bus ();

    swt16_loader #(
        .ADDR_WIDTH(12), .WORD_WIDTH(16), .ADDR_INCREMENT(2), .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic        dmem;
        logic [11:0] addr;
        logic [15:0] word;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] wdata[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          m_err;
    bit          m_done;
    int          m_words;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (bus.out_pmem_wr_en === 1'b1 || bus.out_dmem_wr_en === 1'b1) begin
            check("dual_strobe", 32'(bus.out_pmem_wr_en & bus.out_dmem_wr_en), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h word %0h expected no write",
                         bus.out_wr_addr, bus.out_wr_word);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_dmem", 32'(bus.out_dmem_wr_en), 32'(e.dmem));
                check("wr_addr", 32'(bus.out_wr_addr), 32'(e.addr));
                check("wr_word", 32'(bus.out_wr_word), 32'(e.word));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int tmo, output bit ok);
        int n = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (!bus.out_ready && n < tmo) begin
            @(posedge clock); #1;
            n++;
        end
        ok = bus.out_ready;
        if (ok) begin
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] b);
        bit ok;
        if ($urandom_range(3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
        send_byte(b, 50, ok);
        check("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, 32'(bus.out_core_reset), 32'd1);
        check({tag, "_ready"},      32'(bus.out_ready), 32'd0);
        check({tag, "_pmem_en"},    32'(bus.out_pmem_wr_en), 32'd0);
        check({tag, "_dmem_en"},    32'(bus.out_dmem_wr_en), 32'd0);
        check({tag, "_addr"},       32'(bus.out_wr_addr), 32'd0);
        check({tag, "_word"},       32'(bus.out_wr_word), 32'd0);
        check({tag, "_done"},       32'(bus.out_done), 32'd0);
        check({tag, "_error"},      32'(bus.out_error), 32'd0);
        check({tag, "_words"},      32'(bus.out_words_loaded), 32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        exp_q.delete();
        m_err   = 1'b0;
        m_done  = 1'b0;
        m_words = 0;
        #1;
        check_reset_vals("rst");
        @(posedge clock); #1;
        check("rst_ready_hold", 32'(bus.out_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ready_before_edge", 32'(bus.out_ready), 32'd0);
        @(posedge clock); #1;
        check("ready_after_release", 32'(bus.out_ready), 32'd1);
    endtask

    task automatic check_status();
        @(negedge clock);
        check("error",         32'(bus.out_error), 32'(m_err));
        check("done",          32'(bus.out_done), 32'(m_done));
        check("core_reset",    32'(bus.out_core_reset), 32'(!m_done));
        check("ready",         32'(bus.out_ready), 32'(!(m_err || m_done)));
        check("words_loaded",  32'(bus.out_words_loaded), 32'(m_words));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic fill_words(input int len);
        wdata.delete();
        for (int i = 0; i < len; i++)
            wdata.push_back(16'($urandom()));
    endtask

    // csum_sel < 0 sends the correct checksum, otherwise that byte value.
    task automatic run_frame(input logic [7:0] t, input logic [15:0] a,
                             input logic [15:0] len, input int csum_sel);
        logic [7:0] fb[$];
        logic [7:0] cs = 8'h00;
        logic [7:0] cbyte;
        int         n_acc;
        for (int i = 0; i < int'(len); i++)
            cs = cs ^ wdata[i][15:8] ^ wdata[i][7:0];
        cbyte = (csum_sel < 0) ? cs : 8'(csum_sel);
        fb = '{8'hA5, t, a[15:8], a[7:0], len[15:8], len[7:0]};
        for (int i = 0; i < int'(len); i++) begin
            fb.push_back(wdata[i][15:8]);
            fb.push_back(wdata[i][7:0]);
        end
        fb.push_back(cbyte);

        if (t == 8'hFF) begin
            n_acc = 2; m_done = 1'b1;
        end else if (t != 8'h00 && t != 8'h01) begin
            n_acc = 2; m_err = 1'b1;
        end else if (int'(a) >= 4096 || a[0]) begin
            n_acc = 4; m_err = 1'b1;
        end else if (len == 0 || int'(a) + 2 * int'(len) > 4096) begin
            n_acc = 6; m_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                exp_q.push_back('{dmem: t[0], addr: 12'(int'(a) + 2 * i), word: wdata[i]});
                if (m_words < 4095) m_words++;
            end
            n_acc = 7 + 2 * int'(len);
            if (cbyte != cs) m_err = 1'b1;
        end

        for (int i = 0; i < n_acc; i++)
            send_exp(fb[i]);
        check_status();
    endtask

    task automatic check_locked();
        bit ok;
        send_byte(8'hA5, 5, ok);
        check("locked_no_accept", 32'(ok), 32'd0);
        send_byte(8'hFF, 5, ok);
        check("locked_core_reset", 32'(bus.out_core_reset), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // PMEM two-word load
        wdata = '{16'h1234, 16'hABCD};
        run_frame(8'h00, 16'h0010, 16'd2, -1);

        // Junk byte, DMEM load at top word, then GO
        send_exp(8'h3C);
        wdata = '{16'hBEEF};
        run_frame(8'h01, 16'h0FFE, 16'd1, -1);
        run_frame(8'hFF, 16'h0000, 16'd0, -1);

        // Bounds errors
        do_reset();
        fill_words(2);
        run_frame(8'h00, 16'h0FFE, 16'd2, -1);
        check_locked();
        do_reset();
        fill_words(1);
        run_frame(8'h00, 16'h0011, 16'd1, -1);
        check_locked();
        do_reset();
        wdata.delete();
        run_frame(8'h00, 16'h0020, 16'd0, -1);
        check_locked();
        do_reset();
        fill_words(1);
        run_frame(8'h00, 16'h1000, 16'd1, -1);
        check_locked();

        // Checksum mismatch: 12^34 = 26, send 00
        do_reset();
        wdata = '{16'h1234};
        run_frame(8'h00, 16'h0100, 16'd1, 8'h00);
        check_locked();

        // Reset mid-payload after DATA_HI accepted
        do_reset();
        send_exp(8'hA5); send_exp(8'h00); send_exp(8'h00);
        send_exp(8'h20); send_exp(8'h00); send_exp(8'h01);
        send_exp(8'h12);
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        repeat (2) begin @(posedge clock); #1; end
        do_reset();
        wdata = '{16'h5678, 16'h9ABC, 16'h0F0F};
        run_frame(8'h01, 16'h0200, 16'd3, -1);

        // Randomized frames
        for (int k = 0; k < 60; k++) begin
            logic [7:0]  t;
            logic [15:0] a;
            logic [15:0] len;
            int          r;
            int          cs_sel;
            if (m_err || m_done) do_reset();
            if ($urandom_range(4) == 0) send_exp(8'($urandom_range(0, 8'hA4)));
            r   = int'($urandom_range(19));
            t   = 8'($urandom_range(1));
            a   = 16'($urandom_range(0, 4095)) & 16'hFFFE;
            len = 16'($urandom_range(1, 6));
            if (r == 0) t = 8'hFF;
            if (r == 1) t = 8'($urandom_range(2, 254));
            if (r == 2) a = 16'($urandom());
            if (r == 3) len = 16'd0;
            if (r == 4) begin a = 16'h0FF0; len = 16'($urandom_range(7, 9)); end
            cs_sel = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : -1;
            fill_words(int'(len));
            run_frame(t, a, len, cs_sel);
        end

        // Full-memory frames: exact upper bound and words_loaded saturation
        do_reset();
        fill_words(2048);
        run_frame(8'h00, 16'h0000, 16'd2048, -1);
        fill_words(2048);
        run_frame(8'h01, 16'h0000, 16'd2048, -1);
        run_frame(8'hFF, 16'h0000, 16'd0, -1);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
